// File: rtl/spram_access_ctrl.sv
// Single-port RAM access controller: arbitrates write/read request streams
// onto one RAM port and returns read data in order through a response FIFO.
module spram_access_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 10,
  parameter int BYTEEN_WIDTH = 2,
  parameter int OUTPUT_REG   = 0,
  parameter int RSP_DEPTH    = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [BYTEEN_WIDTH-1:0] wr_byteen,
  input  logic                    rd_valid,
  output logic                    rd_ready,
  input  logic [ADDR_WIDTH-1:0]   rd_addr,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic                    ram_addren,
  output logic                    ram_wclke,
  output logic                    ram_we,
  output logic [BYTEEN_WIDTH-1:0] ram_byteen,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  output logic                    ram_re,
  input  logic [DATA_WIDTH-1:0]   ram_rdata,
  output logic                    idle
);

  localparam int LAT   = 1 + OUTPUT_REG;
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  generate
    if (RSP_DEPTH < LAT + 2 ||
        (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("RSP_DEPTH must be a power of 2 and >= LAT+2");
    end
    if (BYTEEN_WIDTH * 8 != DATA_WIDTH) begin : g_bad_be
      $error("BYTEEN_WIDTH must equal DATA_WIDTH/8");
    end
    if (OUTPUT_REG < 0 || OUTPUT_REG > 1) begin : g_bad_oreg
      $error("OUTPUT_REG must be 0 or 1");
    end
  endgenerate

  logic [LAT-1:0]        tag_q;
  logic [CNT_W-1:0]      inflight;
  logic [CNT_W-1:0]      fifo_cnt_q;
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
  logic                  last_grant_q;

  logic [OCC_W-1:0] occ;
  logic             credit;
  logic             gnt_wr;
  logic             gnt_rd;
  logic             push;
  logic             pop;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight = inflight + CNT_W'(tag_q[i]);
    end
  end

  // occupancy counts reads not yet popped; a same-cycle pop is not credited
  assign occ    = OCC_W'(inflight) + OCC_W'(fifo_cnt_q);
  assign credit = occ < OCC_W'(RSP_DEPTH);

  always_comb begin
    gnt_rd = 1'b0;
    gnt_wr = 1'b0;
    if (!reset) begin
      gnt_rd = rd_valid && credit &&
               (!wr_valid || !last_grant_q);
      gnt_wr = wr_valid && !gnt_rd;
    end
  end

  assign wr_ready = gnt_wr;
  assign rd_ready = gnt_rd;

  always_comb begin
    ram_addr   = '0;
    ram_addren = 1'b0;
    ram_we     = 1'b0;
    ram_byteen = '0;
    ram_wdata  = '0;
    ram_re     = 1'b0;
    unique case (1'b1)
      gnt_wr: begin
        ram_addr   = wr_addr;
        ram_addren = 1'b1;
        ram_we     = 1'b1;
        ram_byteen = wr_byteen;
        ram_wdata  = wr_data;
      end
      gnt_rd: begin
        ram_addr   = rd_addr;
        ram_addren = 1'b1;
        ram_re     = 1'b1;
      end
      default: begin
        ram_addr   = '0;
        ram_addren = 1'b0;
      end
    endcase
  end

  assign ram_wclke = ram_we;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b0;
    end else if (gnt_wr) begin
      last_grant_q <= 1'b0;
    end else if (gnt_rd) begin
      last_grant_q <= 1'b1;
    end
  end

  // tag leaving the last stage marks the cycle ram_rdata is valid
  assign push = tag_q[LAT-1];
  assign pop  = rsp_valid && rsp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_q <= '0;
    end else begin
      tag_q <= (tag_q << 1) | LAT'(gnt_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= ram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign rsp_valid = fifo_cnt_q != '0;
  assign rsp_data  = rsp_valid ? fifo_mem[rd_ptr_q] : '0;
  assign idle      = (inflight == '0) && (fifo_cnt_q == '0);

endmodule

// File: doc/spram_access_ctrl.md
Name: spram_access_ctrl

Overview:
- Initiator-side controller that drives a single-port block RAM from two independent valid/ready request streams: write and read.
- Arbitrates both streams onto the RAM's one address port, at most one operation per cycle.
- Tracks read latency: 1 cycle, or 2 cycles with the RAM output register enabled.
- Returns read data in issue order through a response FIFO with backpressure. Sits between user logic and the single-port RAM wrapper.

Parameters:
- DATA_WIDTH, 16, RAM word width; multiple of 8.
- ADDR_WIDTH, 10, RAM address width.
- BYTEEN_WIDTH, 2, byte-enable width, equal to DATA_WIDTH/8.
- OUTPUT_REG, 0, must match the RAM's OUTPUT_REG. Read latency LAT = 1 + OUTPUT_REG.
- RSP_DEPTH, 4, response FIFO depth. Power of 2 and at least LAT+2; violation is an elaboration error.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write request accepted this cycle.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- wr_byteen  in  BYTEEN_WIDTH  byte enables, active high.
- rd_valid  in  1  read request valid.
- rd_ready  out  1  read request accepted this cycle.
- rd_addr  in  ADDR_WIDTH  read address.
- rsp_valid  out  1  response data valid.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  DATA_WIDTH  read response data.
- ram_addr  out  ADDR_WIDTH  RAM address.
- ram_addren  out  1  RAM address enable; high on any issue.
- ram_wclke  out  1  RAM write clock enable; equals ram_we.
- ram_we  out  1  RAM write enable.
- ram_byteen  out  BYTEEN_WIDTH  RAM byte enables.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_re  out  1  RAM read enable.
- ram_rdata  in  DATA_WIDTH  RAM read data.
- idle  out  1  no read in flight and response FIFO empty.

Behaviour:
- Handshakes: a transfer occurs on a rising edge where valid && ready. Requesters hold valid and payload stable until accepted.
- Issue is combinational from the current-cycle grant:
  - Write grant: ram_we = ram_wclke = ram_addren = 1, ram_addr = wr_addr, ram_wdata = wr_data, ram_byteen = wr_byteen, ram_re = 0.
  - Read grant: ram_re = ram_addren = 1, ram_addr = rd_addr, ram_we = 0, ram_byteen = 0.
  - No grant: all ram_* enables are 0; ram_addr, ram_wdata and ram_byteen are 0.
- Read eligibility (credit): rd_valid && (inflight + fifo_count) < RSP_DEPTH. This check does not credit a same-cycle pop. inflight is the number of set bits in the LAT-stage read-tag shift register.
- Arbitration:
  - Only one eligible requester: it is granted.
  - Both eligible: round-robin using register last_grant (0 = write, 1 = read); the requester not in last_grant is granted.
  - last_grant updates on every grant. Reset value is 0, so the first contention grants read.
  - Write is never blocked by a read lacking credit, so no idle bubble is inserted.
- Read pipeline:
  - The tag shift register shifts 1 in on read issue and 0 otherwise.
  - When the tag exits stage LAT, ram_rdata is pushed into the FIFO on that edge.
  - rd handshake in cycle N → data in FIFO and rsp_valid high from cycle N+1+LAT.
- Response FIFO:
  - Show-ahead: rsp_data is valid whenever rsp_valid is high.
  - Pop on rsp_valid && rsp_ready.
  - Simultaneous push and pop keeps the count. Pointers wrap modulo RSP_DEPTH.
  - Overflow cannot occur because of the credit check.
- Ordering: responses follow read issue order. A read issued after a write to the same address returns the new data. A read issued before a write returns the old data. Ops are never simultaneous, so the RAM WRITE_MODE is irrelevant.
- Throughput: with rsp_ready held high and RSP_DEPTH ≥ LAT+2, back-to-back reads sustain 1 per cycle.
- Reset, while asserted:
  - wr_ready = rd_ready = 0; all ram_* enables = 0.
  - rsp_valid = 0, idle = 1, rsp_data = 0.
  - Tag register, FIFO pointers/count and last_grant are cleared.
- Reset mid-operation: in-flight reads and queued responses are discarded. No response is produced after reset releases.
- idle = (inflight == 0) && (fifo_count == 0).

Test Plan:
- Write 0xA5A5 to addr 3 (byteen=2'b11), then read addr 3 → rsp_data = 0xA5A5, with rsp_valid rising 2 cycles after the rd handshake (OUTPUT_REG=0), or 3 cycles with OUTPUT_REG=1.
- Byte masking: write 0x1234 to addr 7, then write 0xFFFF to addr 7 with byteen=2'b01, then read addr 7 → 0x12FF.
- Contention: hold wr_valid and rd_valid high for 6 cycles from reset → grants are R,W,R,W,R,W; every wr_ready coincides with rd_ready = 0.
- Backpressure: with rsp_ready = 0, issue reads continuously → exactly RSP_DEPTH (4) rd handshakes, then rd_ready = 0. A pending write is still accepted in the same cycle. Raising rsp_ready then yields the 4 responses in address order.
- Streaming: rsp_ready = 1, 16 back-to-back reads of addrs 0..15 pre-filled with addr*3 → 16 consecutive rsp cycles with data 0,3,…,45 and no gaps.
- Reset mid-flight: assert reset the cycle after a read issues → rsp_valid stays 0 through and after reset, idle = 1, and the next read after release returns correct data.
